// File: rtl/edf_queue_scheduler_if.sv
// Signal bundle between edf_queue_scheduler, its queue bank and the downstream master.
// master = the scheduler; slave = the environment that owns the queues and the sink.
interface edf_queue_scheduler_if #(
    parameter int NUM_QUEUES    = 4,
    parameter int DATA_SIZE     = 8,
    parameter int REGISTER_SIZE = 32
);
    localparam int SOURCE_SIZE = $clog2(NUM_QUEUES);

    logic                                enable;
    logic [NUM_QUEUES*REGISTER_SIZE-1:0] period;
    logic [NUM_QUEUES-1:0]               queue_empty;
    logic [NUM_QUEUES*DATA_SIZE-1:0]     queue_data;
    logic [NUM_QUEUES-1:0]               queue_consumed;
    logic [DATA_SIZE-1:0]                out_data;
    logic [SOURCE_SIZE-1:0]              out_source;
    logic                                out_valid;
    logic                                out_ready;

    modport master (
        input  enable,
        input  period,
        input  queue_empty,
        input  queue_data,
        input  out_ready,
        output queue_consumed,
        output out_data,
        output out_source,
        output out_valid
    );

    modport slave (
        output enable,
        output period,
        output queue_empty,
        output queue_data,
        output out_ready,
        input  queue_consumed,
        input  out_data,
        input  out_source,
        input  out_valid
    );
endinterface

// File: rtl/edf_queue_scheduler.sv
// Earliest-deadline-first arbiter draining NUM_QUEUES queues into one valid/ready port.
// Define MEMOREDF_RR_TIEBREAK_EN to break equal-deadline ties round-robin instead of lowest index.
module edf_queue_scheduler #(
    parameter int NUM_QUEUES    = 4,
    parameter int DATA_SIZE     = 8,
    parameter int REGISTER_SIZE = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    edf_queue_scheduler_if.master bus
);
    localparam int SOURCE_SIZE = $clog2(NUM_QUEUES);

    typedef logic [SOURCE_SIZE-1:0] index_t;
    typedef enum logic [1:0] {IDLE, GRANT, POP, SETTLE} state_t;

    state_t                   state;
    index_t                   sel;
    logic [NUM_QUEUES-1:0]    consumed;
    logic                     valid;
    logic [DATA_SIZE-1:0]     data;
    logic [REGISTER_SIZE-1:0] dl        [NUM_QUEUES];
    logic [REGISTER_SIZE-1:0] period_of [NUM_QUEUES];
    logic [DATA_SIZE-1:0]     head_of   [NUM_QUEUES];

    index_t                   winner;
    logic                     any_candidate;
    logic [REGISTER_SIZE-1:0] best;

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_unpack
        assign period_of[g] = bus.period[g*REGISTER_SIZE +: REGISTER_SIZE];
        assign head_of[g]   = bus.queue_data[g*DATA_SIZE +: DATA_SIZE];
    end

`ifdef MEMOREDF_RR_TIEBREAK_EN
    index_t last_granted;

    // Strict '<' keeps the first minimum met along the rotated search order.
    always_comb begin
        int     idx;
        index_t cand;
        // NOTE: every signal written here gets a default first, so no path through
        // the block leaves it unassigned and no latch is inferred.
        winner        = '0;
        any_candidate = 1'b0;
        best          = '0;
        idx           = 0;
        cand          = '0;
        for (int k = 0; k < NUM_QUEUES; k++) begin
            idx = int'(last_granted) + 1 + k;
            if (idx >= NUM_QUEUES) idx = idx - NUM_QUEUES;
            cand = index_t'(idx);
            if (!bus.queue_empty[cand] && (!any_candidate || dl[cand] < best)) begin
                winner        = cand;
                best          = dl[cand];
                any_candidate = 1'b1;
            end
        end
    end
`else
    // Ascending scan with strict '<' gives ties to the lowest index.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path through
        // the block leaves it unassigned and no latch is inferred.
        winner        = '0;
        any_candidate = 1'b0;
        best          = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            if (!bus.queue_empty[i] && (!any_candidate || dl[i] < best)) begin
                winner        = index_t'(i);
                best          = dl[i];
                any_candidate = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            // NOTE: non-blocking assignments for all state, so every register samples
            // the pre-edge values regardless of statement order.
            state    <= IDLE;
            sel      <= '0;
            consumed <= '0;
            valid    <= 1'b0;
            data     <= '0;
            // NOTE: dl is a small flop array whose value is architecturally visible from
            // the first cycle, so it is reset explicitly; a true RAM would not be.
            for (int i = 0; i < NUM_QUEUES; i++) begin
                dl[i] <= period_of[i];
            end
`ifdef MEMOREDF_RR_TIEBREAK_EN
            last_granted <= index_t'(NUM_QUEUES - 1);
`endif
        end else begin
            // A pop or an empty queue restarts the deadline; otherwise count down to 0 and stick.
            for (int i = 0; i < NUM_QUEUES; i++) begin
                if (consumed[i] || bus.queue_empty[i]) begin
                    dl[i] <= period_of[i];
                end else if (dl[i] != '0) begin
                    dl[i] <= dl[i] - REGISTER_SIZE'(1);
                end
            end

            consumed <= '0;

            case (state)
                IDLE: begin
                    if (bus.enable && any_candidate) begin
                        state <= GRANT;
                        sel   <= winner;
                        valid <= 1'b1;
                        data  <= head_of[winner];
                    end
                end
                GRANT: begin
                    if (bus.out_ready) begin
                        state    <= POP;
                        valid    <= 1'b0;
                        consumed <= NUM_QUEUES'(1) << sel;
                    end
                end
                POP: begin
                    state <= SETTLE;
`ifdef MEMOREDF_RR_TIEBREAK_EN
                    last_granted <= sel;
`endif
                end
                SETTLE: begin
                    // Gives the queue one cycle to present its new head and empty flag.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.queue_consumed = consumed;
    assign bus.out_valid      = valid;
    assign bus.out_source     = sel;
    assign bus.out_data       = data;
endmodule

// File: tb/tb_edf_queue_scheduler.sv
// Bench for edf_queue_scheduler: a bench-owned queue bank, a transaction-level EDF model
// compared every cycle, directed literal scenarios and a randomized run.
module tb_edf_queue_scheduler;
    localparam int NQ    = 4;
    localparam int DS    = 8;
    localparam int RS    = 32;
    localparam int DEPTH = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    edf_queue_scheduler_if #(.NUM_QUEUES(NQ), .DATA_SIZE(DS), .REGISTER_SIZE(RS)) bus ();

    edf_queue_scheduler #(.NUM_QUEUES(NQ), .DATA_SIZE(DS), .REGISTER_SIZE(RS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DS-1:0] mem [NQ][DEPTH];
    int            cnt [NQ] = '{default: 0};
    logic [NQ-1:0] pend_pop = '0;
    int            grant_log [$];

    // Model state: timeline of the current grant rather than an FSM encoding.
    logic [RS-1:0] m_dl [NQ];
    bit            m_active;
    int            m_src;
    logic [DS-1:0] m_data;
    int            m_pop_cycle;
    int            m_next_eval;
    int            m_last;
    int            cyc = 0;
    bit            m_started = 1'b0;
    bit            prev_valid = 1'b0;
    logic [NQ-1:0] exp_cons;
    int            win;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [RS-1:0] per(input int i);
        return bus.period[i*RS +: RS];
    endfunction

    task automatic set_period(input int i, input logic [RS-1:0] v);
        bus.period[i*RS +: RS] = v;
    endtask

    task automatic push(input int i, input logic [DS-1:0] d);
        if (cnt[i] < DEPTH) begin
            mem[i][cnt[i]] = d;
            cnt[i]++;
        end
    endtask

    task automatic pop(input int i);
        if (cnt[i] > 0) begin
            for (int j = 0; j < DEPTH - 1; j++) mem[i][j] = mem[i][j+1];
            cnt[i]--;
        end
    endtask

    task automatic drive_queues();
        for (int i = 0; i < NQ; i++) begin
            bus.queue_empty[i]        = (cnt[i] == 0);
            bus.queue_data[i*DS +: DS] = (cnt[i] > 0) ? mem[i][0] : '0;
        end
    endtask

    function automatic bit queues_busy();
        for (int i = 0; i < NQ; i++) if (cnt[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    // Queue bank reacts to the pop strobe seen in the previous cycle.
    task automatic tick();
        @(posedge clock);
        #1;
        for (int i = 0; i < NQ; i++) if (pend_pop[i]) pop(i);
        drive_queues();
    endtask

    // EDF rule: smallest deadline among non-empty queues; ties by search order.
    function automatic int model_winner();
        logic [RS-1:0] least = '0;
        bit            found = 1'b0;
        int            start = 0;
        for (int i = 0; i < NQ; i++) begin
            if (cnt[i] > 0 && (!found || m_dl[i] < least)) begin
                least = m_dl[i];
                found = 1'b1;
            end
        end
        if (!found) return -1;
`ifdef MEMOREDF_RR_TIEBREAK_EN
        start = (m_last + 1) % NQ;
`endif
        for (int k = 0; k < NQ; k++) begin
            if (cnt[(start + k) % NQ] > 0 && m_dl[(start + k) % NQ] == least) return (start + k) % NQ;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_active    = 1'b0;
        m_src       = 0;
        m_data      = '0;
        m_pop_cycle = -1;
        m_next_eval = cyc + 1;
        m_last      = NQ - 1;
        for (int i = 0; i < NQ; i++) m_dl[i] = per(i);
    endfunction

    always @(negedge clock) begin
        if (!m_started) begin
            model_reset();
            m_started = 1'b1;
        end
        exp_cons = (cyc == m_pop_cycle) ? (NQ'(1) << m_src) : '0;

        check("out_valid", bus.out_valid, m_active);
        check("out_source", bus.out_source, m_src);
        check("queue_consumed", bus.queue_consumed, exp_cons);
        if (m_active) check("out_data", bus.out_data, m_data);
        for (int i = 0; i < NQ; i++) check($sformatf("dl[%0d]", i), dut.dl[i], m_dl[i]);

        if (bus.out_valid && !prev_valid) grant_log.push_back(int'(bus.out_source));
        prev_valid = bus.out_valid;
        pend_pop   = bus.queue_consumed;

        if (!reset) begin
            model_reset();
        end else begin
            win = model_winner();
            for (int i = 0; i < NQ; i++) begin
                if (exp_cons[i] || cnt[i] == 0) m_dl[i] = per(i);
                else if (m_dl[i] != 0)          m_dl[i] = m_dl[i] - 1;
            end
            if (cyc == m_pop_cycle) m_last = m_src;
            if (m_active) begin
                if (bus.out_ready) begin
                    m_active    = 1'b0;
                    m_pop_cycle = cyc + 1;
                    m_next_eval = cyc + 3;
                end
            end else if (cyc >= m_next_eval && bus.enable && win >= 0) begin
                m_active = 1'b1;
                m_src    = win;
                m_data   = mem[win][0];
            end
        end
        cyc++;
    end

    task automatic drain();
        int budget = 300;
        bus.out_ready = 1'b1;
        bus.enable    = 1'b1;
        while ((queues_busy() || bus.out_valid) && budget > 0) begin
            tick();
            budget--;
        end
        check("drain finished", budget > 0, 1);
        repeat (4) tick();
    endtask

    task automatic wait_grants(input int base, input int n);
        int budget = 200;
        while (grant_log.size() < base + n && budget > 0) begin
            tick();
            budget--;
        end
        check("grant count", grant_log.size() >= base + n, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_period [NQ] = '{7, 11, 13, 17};
        int edf_order  [NQ] = '{1, 3, 2, 0};
`ifdef MEMOREDF_RR_TIEBREAK_EN
        int tie_order  [NQ] = '{0, 1, 2, 3};
`else
        int tie_order  [NQ] = '{0, 0, 0, 1};
`endif
        int base;
        int budget;
        logic [1:0]    held_src;
        logic [DS-1:0] held_data;

        bus.enable      = 1'b1;
        bus.out_ready   = 1'b0;
        bus.period      = '0;
        bus.queue_empty = '1;
        bus.queue_data  = '0;
        for (int i = 0; i < NQ; i++) set_period(i, RS'(exp_period[i]));
        for (int i = 0; i < NQ; i++) push(i, DS'(8'h10 + i));
        drive_queues();

        // Reset held with every queue non-empty.
        repeat (3) begin
            tick();
            check("reset out_valid", bus.out_valid, 0);
            check("reset queue_consumed", bus.queue_consumed, 0);
            check("reset out_source", bus.out_source, 0);
            check("reset out_data", bus.out_data, 0);
        end
        for (int i = 0; i < NQ; i++) cnt[i] = 0;
        drive_queues();
        tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < NQ; i++) check("dl after reset", dut.dl[i], exp_period[i]);
        drain();

        // Single queue: latency and four-cycle turnaround.
        push(2, 8'hA5);
        push(2, 8'h3C);
        drive_queues();
        bus.out_ready = 1'b1;
        tick();
        check("single valid", bus.out_valid, 1);
        check("single source", bus.out_source, 2);
        check("single data", bus.out_data, 8'hA5);
        tick();
        check("single pop", bus.queue_consumed, 4'b0100);
        check("single valid drop", bus.out_valid, 0);
        tick();
        check("settle no pop", bus.queue_consumed, 0);
        tick();
        check("idle no valid", bus.out_valid, 0);
        tick();
        check("second grant valid", bus.out_valid, 1);
        check("second grant data", bus.out_data, 8'h3C);
        drain();

        // EDF ordering.
        set_period(0, 40); set_period(1, 10); set_period(2, 30); set_period(3, 20);
        tick();
        base = grant_log.size();
        for (int i = 0; i < NQ; i++) push(i, DS'(8'h20 + i));
        drive_queues();
        wait_grants(base, NQ);
        for (int k = 0; k < NQ; k++)
            if (grant_log.size() > base + k) check("edf order", grant_log[base + k], edf_order[k]);
        drain();

        // Backpressure with enable dropped mid-grant.
        bus.out_ready = 1'b0;
        push(1, 8'h5A);
        push(1, 8'h6B);
        drive_queues();
        budget = 20;
        while (!bus.out_valid && budget > 0) begin
            tick();
            budget--;
        end
        check("bp grant", bus.out_valid, 1);
        check("bp source", bus.out_source, 1);
        check("bp data", bus.out_data, 8'h5A);
        held_src  = bus.out_source;
        held_data = bus.out_data;
        for (int k = 1; k <= 10; k++) begin
            if (k == 3) bus.enable = 1'b0;
            tick();
            check("bp held valid", bus.out_valid, 1);
            check("bp held source", bus.out_source, held_src);
            check("bp held data", bus.out_data, held_data);
            check("bp no pop", bus.queue_consumed, 0);
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp pop", bus.queue_consumed, 4'b0010);
        drain();

        // Deadline saturation.
        set_period(0, 3);
        tick();
        bus.out_ready = 1'b0;
        push(0, 8'h77);
        drive_queues();
        repeat (10) tick();
        check("saturated dl0", dut.dl[0], 0);
        check("saturation grant source", bus.out_source, 0);
        drain();

        // Ties at permanent urgency, fresh round-robin pointer.
        for (int i = 0; i < NQ; i++) set_period(i, 0);
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        base = grant_log.size();
        for (int i = 0; i < NQ; i++) repeat (3) push(i, DS'(8'h40 + i));
        drive_queues();
        wait_grants(base, NQ);
        for (int k = 0; k < NQ; k++)
            if (grant_log.size() > base + k) check("tie order", grant_log[base + k], tie_order[k]);
        drain();

        // Equal periods of 5, followed only by the model.
        for (int i = 0; i < NQ; i++) set_period(i, 5);
        tick();
        for (int i = 0; i < NQ; i++) repeat (2) push(i, DS'(8'h50 + i));
        drive_queues();
        drain();

        // Randomized traffic, backpressure, period changes and sporadic resets.
        for (int c = 0; c < 3000; c++) begin
            tick();
            if ($urandom_range(0, 2) == 0) push(int'($urandom_range(0, NQ - 1)), DS'($urandom));
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.enable    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0)
                set_period(int'($urandom_range(0, NQ - 1)), RS'($urandom_range(0, 20)));
            reset = ($urandom_range(0, 299) != 0);
            drive_queues();
        end
        reset = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
